clkdiv_update_seq: RTL and testbench
====================================

Name: clkdiv_update_seq

Overview:
- Sequences runtime clock-divider reprogramming for the two SoC clock dividers (div0, div1) behind the APB SoC control register block.
- Captures the single-cycle divider write pulses and shares one divider configuration bus between the two channels using round-robin arbitration.
- For each update it gates the affected clock, pushes the new ratio with a valid/ack handshake, waits for the divider to settle, then ungates the clock.

Parameters:
- DIV_WIDTH, 8, width of a divider ratio.
- GATE_CYCLES, 4, cycles the clock enable is held low before the ratio is pushed (>=1).
- SETTLE_CYCLES, 8, cycles after ack or timeout before the clock is ungated (>=1).
- ACK_TIMEOUT, 64, maximum PUSH cycles to wait for div_ack_i (>=1).

Ports:
- HCLK  in  1  system clock
- HRESET  in  1  synchronous reset, active-high
- div0_value_i  in  DIV_WIDTH  new ratio for divider 0
- div0_valid_i  in  1  single-cycle write strobe for divider 0
- div1_value_i  in  DIV_WIDTH  new ratio for divider 1
- div1_valid_i  in  1  single-cycle write strobe for divider 1
- div_data_o  out  DIV_WIDTH  ratio on the shared configuration bus
- div_sel_o  out  1  target divider (0/1)
- div_valid_o  out  1  configuration bus valid
- div_ack_i  in  1  divider accepted data (sampled while div_valid_o=1)
- clk_en0_o  out  1  clock enable, divider 0 output
- clk_en1_o  out  1  clock enable, divider 1 output
- busy_o  out  1  sequence in progress (state != IDLE)
- pending_o  out  2  per-channel pending flags
- timeout_o  out  1  one-cycle pulse when PUSH times out

Behaviour:
Reset values (HRESET=1, sampled on the HCLK edge):
- clk_en0_o=clk_en1_o=1; all other outputs 0.
- State IDLE; pending cleared; last_grant=1, so channel 0 wins the first tie.

Capture:
- divN_valid_i=1 sets pend[N] and stores divN_value_i in hold[N]; the latest write wins.
- A strobe arriving while channel N is being serviced re-sets pend[N]. The channel is sequenced again afterwards with the newer value.

FSM IDLE -> GATE -> PUSH -> SETTLE -> IDLE:
- IDLE:
  - If any pend bit is set, grant a channel: the only pending one, or !last_grant when both are pending.
  - On grant: register div_sel_o, load div_data_o from hold[grant], clear pend[grant] (unless its strobe arrives in the same cycle), update last_grant, go to GATE.
  - Minimum latency from strobe to leaving IDLE is 1 cycle.
- GATE:
  - clk_en of the selected channel = 0 from the first GATE cycle.
  - Stay GATE_CYCLES cycles, then go to PUSH.
- PUSH:
  - div_valid_o=1; div_data_o and div_sel_o held stable.
  - Transfer completes in the cycle where div_valid_o && div_ack_i; then div_valid_o drops next cycle and the FSM goes to SETTLE.
  - If no ack after ACK_TIMEOUT cycles: pulse timeout_o for 1 cycle, drop div_valid_o, go to SETTLE.
- SETTLE:
  - SETTLE_CYCLES cycles with the clock still gated, then IDLE.
  - clk_en returns to 1 in the first IDLE cycle.
- The non-selected channel's clk_en stays 1 throughout.

Other rules:
- A single down-counter sized $clog2(max(GATE_CYCLES,SETTLE_CYCLES,ACK_TIMEOUT))+1 serves all states. It is reloaded on every state entry.
- div_ack_i outside PUSH is ignored.
- HRESET mid-sequence returns to the reset values in the next cycle: clocks ungated, pending updates discarded, no timeout pulse.
- Back-to-back: if pend is set on the cycle IDLE is entered, the next grant occurs in that IDLE cycle (1 idle cycle between sequences).

Optional Feature:
- Macro CLKDIV_SEQ_SKIP_SAME_EN.
- Defined:
  - Keep applied[N]; reset value 0; updated on ack (not on timeout).
  - At grant, if hold[N]==applied[N], clear pend[N] and stay in IDLE. The skipped request produces no gating and no bus activity.
- Undefined: every captured write runs the full sequence.

Decomposition:
- Package clkdiv_seq_pkg:
  - State enum typedef seq_state_t (IDLE/GATE/PUSH/SETTLE).
  - Default timing constants.
  - Channel-index localparams.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter (req[1:0], last_grant -> grant, valid).
- Capture registers and FSM stay in the top module.

Test Plan:
- Single update: div0 strobe with value 0x05, ack on the 2nd PUSH cycle.
  - clk_en0_o low for 4+2+8=14 cycles.
  - div_data_o=0x05, div_sel_o=0; clk_en1_o stays 1.
- Simultaneous strobes after reset: div0=0x03, div1=0x07.
  - Channel 0 is serviced first, channel 1 second.
  - 1 IDLE cycle between the two sequences; pending_o goes 11 -> 10 -> 00.
- Overwrite during service: div0=0x02 strobe, then div0=0x09 strobe during GATE.
  - First sequence pushes 0x02, then a second sequence pushes 0x09.
- Ack timeout: never assert ack.
  - div_valid_o high for exactly 64 cycles.
  - timeout_o pulses once, then SETTLE, then clk_en restored.
- Reset mid-PUSH: assert HRESET for 1 cycle.
  - Next cycle: clk_en0_o=clk_en1_o=1, div_valid_o=0, busy_o=0, pending_o=00.
- With CLKDIV_SEQ_SKIP_SAME_EN: write div1=0x04 and ack it, then write 0x04 again.
  - Second write produces no gating and no bus activity; pending_o[1] clears within 1 cycle.

Source files
------------

// File: rtl/clkdiv_seq_pkg.sv
// Shared types and constants for the clock-divider update sequencer.
package clkdiv_seq_pkg;

    // Sequencer states: gate the clock, push the ratio, let it settle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        PUSH   = 2'd2,
        SETTLE = 2'd3
    } seq_state_t;

    // Default timing, in HCLK cycles.
    localparam int DEF_DIV_WIDTH     = 8;
    localparam int DEF_GATE_CYCLES   = 4;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_ACK_TIMEOUT   = 64;

    // Channel indices on the shared configuration bus.
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Largest of three values; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes to
// the channel that was not granted last time.
module rr_arb2
    import clkdiv_seq_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // Pick the winning channel from the request vector and the previous winner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        grant = CH0;
        case (req)
            2'b01:   grant = CH0;
            2'b10:   grant = CH1;
            2'b11:   grant = ~last_grant;
            default: grant = CH0;
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/clkdiv_update_seq.sv
// Runtime reprogramming sequencer for the two SoC clock dividers.
// Captures divider write strobes, arbitrates the shared configuration bus
// round-robin, and for each update gates the clock, pushes the ratio with a
// valid/ack handshake, waits for the divider to settle and ungates the clock.
// Optional build macro CLKDIV_SEQ_SKIP_SAME_EN: drop requests whose ratio
// equals the last ratio the divider acknowledged.
module clkdiv_update_seq
    import clkdiv_seq_pkg::*;
#(
    parameter int DIV_WIDTH     = DEF_DIV_WIDTH,
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [DIV_WIDTH-1:0] div0_value_i,
    input  logic                 div0_valid_i,
    input  logic [DIV_WIDTH-1:0] div1_value_i,
    input  logic                 div1_valid_i,
    output logic [DIV_WIDTH-1:0] div_data_o,
    output logic                 div_sel_o,
    output logic                 div_valid_o,
    input  logic                 div_ack_i,
    output logic                 clk_en0_o,
    output logic                 clk_en1_o,
    output logic                 busy_o,
    output logic [1:0]           pending_o,
    output logic                 timeout_o
);

    // One down-counter times every phase; it is reloaded on each state entry.
    localparam int CNT_MAX = max3(GATE_CYCLES, SETTLE_CYCLES, ACK_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LOAD    = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           pend;
    logic [1:0]           strobe;
    logic [1:0]           clr;
    logic [DIV_WIDTH-1:0] hold [2];
    logic                 last_grant;
    logic                 arb_grant;
    logic                 arb_valid;
    logic                 grant_fire;
    logic                 start;

    assign strobe     = {div1_valid_i, div0_valid_i};
    assign grant_fire = (state == IDLE) && arb_valid;
    assign busy_o     = (state != IDLE);
    assign pending_o  = pend;

    rr_arb2 u_arb (
        .req        (pend),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

`ifdef CLKDIV_SEQ_SKIP_SAME_EN
    logic [DIV_WIDTH-1:0] applied [2];

    // A granted request only runs if its ratio differs from what the divider already holds.
    assign start = grant_fire && (hold[arb_grant] != applied[arb_grant]);
`else
    assign start = grant_fire;
`endif

    // Pending bit of the granted channel is consumed at grant time.
    always_comb begin
        clr = '0;
        if (grant_fire) begin
            clr[arb_grant] = 1'b1;
        end
    end

    // Pending flags: a new strobe always wins over the grant-time clear.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr) | strobe;
        end
    end

    // Latest written ratio per channel.
    // NOTE: hold is pure data qualified by pend, so it carries no reset and stays a plain register bank.
    always_ff @(posedge HCLK) begin
        if (div0_valid_i) begin
            hold[CH0] <= div0_value_i;
        end
        if (div1_valid_i) begin
            hold[CH1] <= div1_value_i;
        end
    end

    // Sequencer FSM with registered bus, clock-enable and timeout outputs.
    always_ff @(posedge HCLK) begin
        // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
        if (HRESET) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= CH1;
            div_data_o  <= '0;
            div_sel_o   <= CH0;
            div_valid_o <= 1'b0;
            clk_en0_o   <= 1'b1;
            clk_en1_o   <= 1'b1;
            timeout_o   <= 1'b0;
`ifdef CLKDIV_SEQ_SKIP_SAME_EN
            applied[CH0] <= '0;
            applied[CH1] <= '0;
`endif
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        last_grant <= arb_grant;
                    end
                    if (start) begin
                        div_sel_o  <= arb_grant;
                        div_data_o <= hold[arb_grant];
                        clk_en0_o  <= (arb_grant != CH0);
                        clk_en1_o  <= (arb_grant != CH1);
                        cnt        <= GATE_LOAD;
                        state      <= GATE;
                    end
                end
                GATE: begin
                    if (cnt == '0) begin
                        div_valid_o <= 1'b1;
                        cnt         <= ACK_LOAD;
                        state       <= PUSH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PUSH: begin
                    if (div_valid_o && div_ack_i) begin
                        div_valid_o <= 1'b0;
                        cnt         <= SETTLE_LOAD;
                        state       <= SETTLE;
`ifdef CLKDIV_SEQ_SKIP_SAME_EN
                        applied[div_sel_o] <= div_data_o;
`endif
                    end else if (cnt == '0) begin
                        timeout_o   <= 1'b1;
                        div_valid_o <= 1'b0;
                        cnt         <= SETTLE_LOAD;
                        state       <= SETTLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        clk_en0_o <= 1'b1;
                        clk_en1_o <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_update_seq.sv
// Directed bench for clkdiv_update_seq: a cycle table for a single update,
// then hand sequences for arbitration, overwrite, timeout, reset and skip.
module tb_clkdiv_update_seq;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [7:0] div0_value_i;
    logic       div0_valid_i;
    logic [7:0] div1_value_i;
    logic       div1_valid_i;
    logic [7:0] div_data_o;
    logic       div_sel_o;
    logic       div_valid_o;
    logic       div_ack_i;
    logic       clk_en0_o;
    logic       clk_en1_o;
    logic       busy_o;
    logic [1:0] pending_o;
    logic       timeout_o;

    always #5 HCLK = ~HCLK;

    clkdiv_update_seq #(
        .DIV_WIDTH     (8),
        .GATE_CYCLES   (4),
        .SETTLE_CYCLES (8),
        .ACK_TIMEOUT   (64)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .div0_value_i (div0_value_i),
        .div0_valid_i (div0_valid_i),
        .div1_value_i (div1_value_i),
        .div1_valid_i (div1_valid_i),
        .div_data_o   (div_data_o),
        .div_sel_o    (div_sel_o),
        .div_valid_o  (div_valid_o),
        .div_ack_i    (div_ack_i),
        .clk_en0_o    (clk_en0_o),
        .clk_en1_o    (clk_en1_o),
        .busy_o       (busy_o),
        .pending_o    (pending_o),
        .timeout_o    (timeout_o)
    );

    typedef struct packed {
        logic       en0;
        logic       en1;
        logic       valid;
        logic       sel;
        logic [7:0] data;
        logic       busy;
        logic [1:0] pend;
        logic       to;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] val0;
        logic       ack;
        int         reps;
        outs_t      exp;
    } vec_t;

    vec_t tbl [8];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic outs_t mko(input logic en0, input logic en1, input logic valid,
                                  input logic sel, input logic [7:0] data, input logic busy,
                                  input logic [1:0] pend, input logic to);
        outs_t o;
        o.en0 = en0; o.en1 = en1; o.valid = valid; o.sel = sel;
        o.data = data; o.busy = busy; o.pend = pend; o.to = to;
        return o;
    endfunction

    function automatic vec_t mkv(input logic rst, input logic v0, input logic [7:0] val0,
                                 input logic ack, input int reps, input outs_t exp);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.val0 = val0; v.ack = ack; v.reps = reps; v.exp = exp;
        return v;
    endfunction

    function automatic outs_t sample();
        return mko(clk_en0_o, clk_en1_o, div_valid_o, div_sel_o, div_data_o,
                   busy_o, pending_o, timeout_o);
    endfunction

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic strobes_off();
        div0_valid_i = 1'b0;
        div1_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        strobes_off();
        step();
        HRESET = 1'b0;
    endtask

    // Steps until busy_o drops, returning the number of steps taken.
    task automatic wait_idle(input string name, input int max_cyc, output int cyc);
        cyc = 0;
        while (busy_o && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check({name, "_idle_reached"}, busy_o, 1'b0);
    endtask

    // Steps until div_valid_o rises, bounded.
    task automatic wait_valid(input string name, input int max_cyc);
        int k;
        k = 0;
        while (!div_valid_o && k < max_cyc) begin
            step();
            k++;
        end
        check({name, "_valid_seen"}, div_valid_o, 1'b1);
    endtask

    initial begin
        int cyc;
        int vcnt;
        int tcnt;
        int scnt;
        int en_bad;
        logic seen_to;

        HRESET       = 1'b1;
        div0_value_i = '0;
        div1_value_i = '0;
        div_ack_i    = 1'b0;
        strobes_off();

        // Single div0 update to 0x05, ack on the 2nd PUSH cycle; ack during GATE is ignored.
        tbl[0] = mkv(1'b1, 1'b0, 8'h00, 1'b0, 2, mko(1, 1, 0, 0, 8'h00, 0, 2'b00, 0));
        tbl[1] = mkv(1'b0, 1'b1, 8'h05, 1'b0, 1, mko(1, 1, 0, 0, 8'h00, 0, 2'b01, 0));
        tbl[2] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1, mko(0, 1, 0, 0, 8'h05, 1, 2'b00, 0));
        tbl[3] = mkv(1'b0, 1'b0, 8'h00, 1'b1, 3, mko(0, 1, 0, 0, 8'h05, 1, 2'b00, 0));
        tbl[4] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 2, mko(0, 1, 1, 0, 8'h05, 1, 2'b00, 0));
        tbl[5] = mkv(1'b0, 1'b0, 8'h00, 1'b1, 1, mko(0, 1, 0, 0, 8'h05, 1, 2'b00, 0));
        tbl[6] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 7, mko(0, 1, 0, 0, 8'h05, 1, 2'b00, 0));
        tbl[7] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 2, mko(1, 1, 0, 0, 8'h05, 0, 2'b00, 0));

        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                HRESET       = tbl[i].rst;
                div0_valid_i = tbl[i].v0;
                div0_value_i = tbl[i].val0;
                div_ack_i    = tbl[i].ack;
                step();
                check($sformatf("vec%0d.%0d", i, r), 32'(sample()), 32'(tbl[i].exp));
            end
        end
        HRESET = 1'b0;
        strobes_off();
        div_ack_i = 1'b0;

        // Simultaneous strobes: channel 0 first, one idle cycle, then channel 1.
        do_reset();
        div_ack_i    = 1'b1;
        div0_valid_i = 1'b1; div0_value_i = 8'h03;
        div1_valid_i = 1'b1; div1_value_i = 8'h07;
        step();
        strobes_off();
        check("sim_pend11", pending_o, 2'b11);
        step();
        check("sim_g0_out", 32'(sample()), 32'(mko(0, 1, 0, 0, 8'h03, 1, 2'b10, 0)));
        wait_idle("sim_ch0", 40, cyc);
        check("sim_ch0_len", cyc, 13);
        check("sim_gap_out", 32'(sample()), 32'(mko(1, 1, 0, 0, 8'h03, 0, 2'b10, 0)));
        step();
        check("sim_g1_out", 32'(sample()), 32'(mko(1, 0, 0, 1, 8'h07, 1, 2'b00, 0)));
        wait_idle("sim_ch1", 40, cyc);
        check("sim_ch1_len", cyc, 13);
        check("sim_en1_back", clk_en1_o, 1'b1);

        // Overwrite during service: 0x02 is pushed, then a second sequence pushes 0x09.
        do_reset();
        div_ack_i    = 1'b1;
        div0_valid_i = 1'b1; div0_value_i = 8'h02;
        step();
        strobes_off();
        step();
        check("ow_grant_data", div_data_o, 8'h02);
        div0_valid_i = 1'b1; div0_value_i = 8'h09;
        step();
        strobes_off();
        check("ow_repend", pending_o, 2'b01);
        wait_valid("ow_first", 20);
        check("ow_first_data", div_data_o, 8'h02);
        wait_idle("ow_first", 40, cyc);
        check("ow_still_pend", pending_o, 2'b01);
        step();
        check("ow_second_grant", 32'(sample()), 32'(mko(0, 1, 0, 0, 8'h09, 1, 2'b00, 0)));
        wait_valid("ow_second", 20);
        check("ow_second_data", div_data_o, 8'h09);
        wait_idle("ow_second", 40, cyc);

        // Ack never arrives on div1: 64 valid cycles, one timeout pulse, 8 settle cycles.
        do_reset();
        div_ack_i    = 1'b0;
        div1_valid_i = 1'b1; div1_value_i = 8'h11;
        step();
        strobes_off();
        step();
        check("to_grant_sel", div_sel_o, 1'b1);
        vcnt = 0; tcnt = 0; scnt = 0; en_bad = 0; seen_to = 1'b0; cyc = 0;
        while (busy_o && cyc < 300) begin
            if (clk_en1_o || !clk_en0_o) en_bad++;
            step();
            cyc++;
            if (div_valid_o) vcnt++;
            if (timeout_o) begin
                tcnt++;
                seen_to = 1'b1;
            end
            if (seen_to && busy_o) scnt++;
        end
        check("to_idle_reached", busy_o, 1'b0);
        check("to_valid_cycles", vcnt, 64);
        check("to_pulses", tcnt, 1);
        check("to_settle_cycles", scnt, 8);
        check("to_gating", en_bad, 0);
        check("to_en_restored", {clk_en0_o, clk_en1_o}, 2'b11);

        // Reset mid-PUSH with a second request pending.
        do_reset();
        div_ack_i    = 1'b0;
        div0_valid_i = 1'b1; div0_value_i = 8'h5A;
        step();
        strobes_off();
        wait_valid("rst", 20);
        div1_valid_i = 1'b1; div1_value_i = 8'h33;
        step();
        strobes_off();
        check("rst_pre_pend", pending_o, 2'b10);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        check("rst_out", 32'(sample()), 32'(mko(1, 1, 0, 0, 8'h00, 0, 2'b00, 0)));
        step();
        check("rst_stays_idle", {busy_o, pending_o}, 3'b000);

        // Rewrite of the same div1 ratio after it was acknowledged.
        do_reset();
        div_ack_i    = 1'b1;
        div1_valid_i = 1'b1; div1_value_i = 8'h04;
        step();
        strobes_off();
        step();
        wait_idle("same_first", 40, cyc);
        div1_valid_i = 1'b1; div1_value_i = 8'h04;
        step();
        strobes_off();
        check("same_pend", pending_o, 2'b10);
        step();
`ifdef CLKDIV_SEQ_SKIP_SAME_EN
        check("skip_out", {pending_o, busy_o, div_valid_o, clk_en1_o}, 5'b00001);
        cyc = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (busy_o || div_valid_o || !clk_en1_o) cyc++;
        end
        check("skip_quiet", cyc, 0);
`else
        check("noskip_runs", {pending_o, busy_o, clk_en1_o}, 4'b0010);
        wait_idle("noskip", 40, cyc);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
